// File: rtl/instr_ext_fetch_pkg.sv
// Shared definitions for the opcode/extension-word fetch block:
// fetch FSM encoding, data bus width and program address defaults.
`ifndef DATABUS
`define DATABUS 24
`endif

package instr_ext_fetch_pkg;

    localparam int unsigned DATABUS_W = `DATABUS;
    localparam int unsigned PAB_W     = 16;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLASSIFY = 2'd1,
        EXT_WAIT = 2'd2,
        OUT      = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_ext_fetch_pc_counter.sv
// Program address counter: reset to RESET_PC, load on redirect,
// increment per accepted word; load has priority over increment.
module instr_ext_fetch_pc_counter
    import instr_ext_fetch_pkg::*;
#(
    parameter int unsigned     AW       = PAB_W,
    parameter logic [AW-1:0]   RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    // Increment wraps modulo 2^AW.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + AW'(1);
        end
    end

endmodule

// File: rtl/instr_ext_fetch.sv
// Pairs each fetched opcode word with its optional extension word and
// hands the assembled 1- or 2-word instruction to decode via valid/ready.
module instr_ext_fetch
    import instr_ext_fetch_pkg::*;
#(
    parameter int unsigned     DW       = DATABUS_W,
    parameter int unsigned     AW       = PAB_W,
    parameter logic [AW-1:0]   RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic [DW-1:0] pdb,
    input  logic          pdb_valid,
    output logic          pdb_ready,
    input  logic          immediate,
    output logic [AW-1:0] pab,
    input  logic          flush,
    input  logic [AW-1:0] flush_addr,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] opcode,
    output logic [DW-1:0] ext_word,
    output logic          has_ext
);

    fetch_state_e state;
    logic         pdb_xfer;

    // Word acceptance depends on state only, except CLASSIFY follows the flag.
    always_comb begin
        pdb_ready = 1'b0;
        if (!flush) begin
            case (state)
                IDLE, EXT_WAIT: pdb_ready = 1'b1;
                CLASSIFY:       pdb_ready = immediate;
                default:        pdb_ready = 1'b0;
            endcase
        end
    end

    assign op_valid = (state == OUT);
    assign pdb_xfer = pdb_valid & pdb_ready;

    instr_ext_fetch_pc_counter #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .Clk       (Clk),
        .reset     (reset),
        .load      (flush),
        .load_addr (flush_addr),
        .inc       (pdb_xfer),
        .pc        (pab)
    );

    // Fetch FSM and instruction holding registers; flush overrides everything but reset.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            opcode   <= '0;
            ext_word <= '0;
            has_ext  <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            ext_word <= '0;
            has_ext  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pdb_xfer) begin
                        opcode <= pdb;
                        state  <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (!immediate) begin
                        ext_word <= '0;
                        has_ext  <= 1'b0;
                        state    <= OUT;
                    end else if (pdb_xfer) begin
                        ext_word <= pdb;
                        has_ext  <= 1'b1;
                        state    <= OUT;
                    end else begin
                        state <= EXT_WAIT;
                    end
                end
                EXT_WAIT: begin
                    if (pdb_xfer) begin
                        ext_word <= pdb;
                        has_ext  <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (op_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_ext_fetch.sv
// Scoreboard bench for instr_ext_fetch: directed instructions push expected
// results; a negedge monitor compares every decode handshake.
module tb_instr_ext_fetch;

    localparam int unsigned DW = 24;
    localparam int unsigned AW = 16;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic          Clk = 1'b0;
    logic          reset;
    logic [DW-1:0] pdb;
    logic          pdb_valid;
    logic          pdb_ready;
    logic          immediate;
    logic [AW-1:0] pab;
    logic          flush;
    logic [AW-1:0] flush_addr;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] opcode;
    logic [DW-1:0] ext_word;
    logic          has_ext;

    typedef struct packed {
        logic [23:0] op;
        logic [23:0] ext;
        logic        he;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_pab;

    instr_ext_fetch #(
        .DW       (DW),
        .AW       (AW),
        .RESET_PC (RST_PC)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
        .pdb        (pdb),
        .pdb_valid  (pdb_valid),
        .pdb_ready  (pdb_ready),
        .immediate  (immediate),
        .pab        (pab),
        .flush      (flush),
        .flush_addr (flush_addr),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opcode     (opcode),
        .ext_word   (ext_word),
        .has_ext    (has_ext)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every completed decode handshake must match the oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (!reset && op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_op: got opcode %h with no expectation queued", opcode);
            end else begin
                e = exp_q.pop_front();
                check("op_opcode", 32'(opcode), 32'(e.op));
                check("op_ext_word", 32'(ext_word), 32'(e.ext));
                check("op_has_ext", 32'(has_ext), 32'(e.he));
            end
        end
    end

    // One instruction from IDLE; stall = cycles pdb_valid stays low after the opcode,
    // bp = cycles decode holds op_ready low in OUT.
    task automatic run_instr(input logic [23:0] op, input logic ext, input logic [23:0] xw,
                             input int stall, input int bp);
        exp_t e;
        e.op  = op;
        e.ext = ext ? xw : 24'h0;
        e.he  = ext;
        exp_q.push_back(e);
        pdb = op; pdb_valid = 1'b1; immediate = 1'b0; op_ready = 1'b1;
        tick();
        exp_pab++;
        immediate = ext;
        if (ext && stall == 0) begin
            pdb = xw; pdb_valid = 1'b1;
        end else begin
            pdb = 24'hDEAD00; pdb_valid = 1'b0;
        end
        @(negedge Clk);
        check("classify_pdb_ready", 32'(pdb_ready), 32'(ext));
        check("classify_op_valid", 32'(op_valid), 32'd0);
        tick();
        if (ext && stall == 0) exp_pab++;
        if (ext && stall > 0) begin
            immediate = 1'b0;
            for (int i = 1; i < stall; i++) begin
                @(negedge Clk);
                check("extwait_pdb_ready", 32'(pdb_ready), 32'd1);
                check("extwait_op_valid", 32'(op_valid), 32'd0);
                check("extwait_pab", 32'(pab), 32'(exp_pab));
                tick();
            end
            pdb = xw; pdb_valid = 1'b1;
            tick();
            exp_pab++;
        end
        pdb = 24'hBAD000; pdb_valid = 1'b0; immediate = 1'b0;
        op_ready = (bp == 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge Clk);
            check("bp_op_valid", 32'(op_valid), 32'd1);
            check("bp_pdb_ready", 32'(pdb_ready), 32'd0);
            check("bp_pab", 32'(pab), 32'(exp_pab));
            check("bp_opcode", 32'(opcode), 32'(op));
            check("bp_ext_word", 32'(ext_word), 32'(e.ext));
            tick();
        end
        op_ready = 1'b1;
        @(negedge Clk);
        check("out_op_valid", 32'(op_valid), 32'd1);
        check("out_pab", 32'(pab), 32'(exp_pab));
        tick();
        @(negedge Clk);
        check("idle_op_valid", 32'(op_valid), 32'd0);
        check("idle_pdb_ready", 32'(pdb_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; pdb = '0; pdb_valid = 1'b0; immediate = 1'b0;
        flush = 1'b0; flush_addr = '0; op_ready = 1'b1;
        #2;
        check("rst_pab", 32'(pab), 32'(RST_PC));
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_pdb_ready", 32'(pdb_ready), 32'd1);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_ext_word", 32'(ext_word), 32'd0);
        check("rst_has_ext", 32'(has_ext), 32'd0);
        tick(); tick();
        reset = 1'b0;
        exp_pab = RST_PC;
        @(negedge Clk);

        run_instr(24'h200013, 1'b0, 24'h0,      0, 0);
        run_instr(24'h0AF080, 1'b1, 24'h001234, 0, 0);
        run_instr(24'h123456, 1'b1, 24'hABCDEF, 4, 0);
        run_instr(24'h0F0F0F, 1'b0, 24'h0,      0, 5);
        run_instr(24'h765432, 1'b1, 24'h00BEEF, 0, 3);

        // Flush while waiting for an extension word
        pdb = 24'h314159; pdb_valid = 1'b1; immediate = 1'b0;
        tick();
        exp_pab++;
        immediate = 1'b1; pdb_valid = 1'b0;
        tick();
        immediate = 1'b0;
        flush = 1'b1; flush_addr = 16'h0040; pdb = 24'h111111; pdb_valid = 1'b1;
        @(negedge Clk);
        check("flush_pdb_ready", 32'(pdb_ready), 32'd0);
        tick();
        flush = 1'b0; pdb_valid = 1'b0;
        exp_pab = 16'h0040;
        @(negedge Clk);
        check("flush_op_valid", 32'(op_valid), 32'd0);
        check("flush_pab", 32'(pab), 32'h0040);
        check("flush_idle_pdb_ready", 32'(pdb_ready), 32'd1);
        run_instr(24'h222222, 1'b0, 24'h0, 0, 0);

        // Flush coinciding with a decode handshake: the instruction still transfers
        begin
            exp_t e;
            e.op = 24'h0C0C0C; e.ext = 24'h0; e.he = 1'b0;
            exp_q.push_back(e);
        end
        pdb = 24'h0C0C0C; pdb_valid = 1'b1; immediate = 1'b0; op_ready = 1'b0;
        tick();
        pdb_valid = 1'b0;
        tick();
        op_ready = 1'b1; flush = 1'b1; flush_addr = 16'hFFFF;
        @(negedge Clk);
        check("flushxfer_op_valid", 32'(op_valid), 32'd1);
        tick();
        flush = 1'b0;
        exp_pab = 16'hFFFF;
        @(negedge Clk);
        check("flushxfer_after_op_valid", 32'(op_valid), 32'd0);
        check("flushxfer_pab", 32'(pab), 32'hFFFF);

        // Address wrap
        run_instr(24'h0ABCDE, 1'b0, 24'h0, 0, 0);
        check("wrap_pab", 32'(pab), 32'h0000);

        // Asynchronous reset while holding an instruction in OUT
        pdb = 24'h555555; pdb_valid = 1'b1; immediate = 1'b0; op_ready = 1'b0;
        tick();
        pdb_valid = 1'b0;
        tick();
        @(negedge Clk);
        check("prereset_op_valid", 32'(op_valid), 32'd1);
        @(posedge Clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_op_valid", 32'(op_valid), 32'd0);
        check("arst_pab", 32'(pab), 32'(RST_PC));
        check("arst_opcode", 32'(opcode), 32'd0);
        check("arst_has_ext", 32'(has_ext), 32'd0);
        check("arst_pdb_ready", 32'(pdb_ready), 32'd1);
        tick();
        reset = 1'b0; op_ready = 1'b1;
        exp_pab = RST_PC;
        @(negedge Clk);
        run_instr(24'h600001, 1'b1, 24'h0000AA, 0, 0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/instr_ext_fetch.md
Name: instr_ext_fetch

Overview:
- Program-side consumer of the extension-word flag: pairs each opcode word fetched on the program data bus with its optional extension (immediate/absolute address) word.
- Presents a complete 1- or 2-word instruction to decode through a valid/ready handshake.
- Sits between program memory fetch and decode. Takes the registered `immediate` flag produced by the immediate-check logic one cycle after the opcode word is on the bus.
- Owns the program address counter and its redirect on flush.

Parameters:
DW, 24, program data word width (equals `databus width)
AW, 16, program address width
RESET_PC, 16'h0000, program address loaded on reset

Ports:
Clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
pdb  in  DW  program data word from memory
pdb_valid  in  1  pdb holds a valid word for address pab
pdb_ready  out  1  block accepts pdb this cycle; word transfer = pdb_valid & pdb_ready
immediate  in  1  registered flag: previous accepted word needs an extension word
pab  out  AW  program address of next word to fetch
flush  in  1  redirect fetch (jump/branch taken)
flush_addr  in  AW  new fetch address on flush
op_valid  out  1  assembled instruction available
op_ready  in  1  decode accepts instruction; transfer = op_valid & op_ready
opcode  out  DW  first instruction word
ext_word  out  DW  extension word; zero when has_ext=0
has_ext  out  1  instruction is two words

Behaviour:
- Reset values: state=IDLE, pab=RESET_PC, opcode=0, ext_word=0, has_ext=0, op_valid=0, pdb_ready=1 (combinational from IDLE).
- FSM states: IDLE, CLASSIFY, EXT_WAIT, OUT.
- IDLE: pdb_ready=1. On transfer: opcode<=pdb, pab<=pab+1, go to CLASSIFY.
- CLASSIFY: `immediate` now corresponds to the stored opcode. The flag is sampled only in this state.
  - If immediate=0: pdb_ready=0, has_ext<=0, ext_word<=0, go to OUT.
  - If immediate=1: pdb_ready=1. On transfer: ext_word<=pdb, has_ext<=1, pab<=pab+1, go to OUT. With no transfer, go to EXT_WAIT.
- EXT_WAIT: pdb_ready=1. Flag ignored; extension pending is held in state. On transfer: capture as in CLASSIFY, go to OUT.
- OUT: op_valid=1, pdb_ready=0. opcode/ext_word/has_ext are stable while op_valid & !op_ready. On op_ready, go to IDLE.
- pdb_ready and op_valid are decoded from state only (no combinational path from op_ready to pdb_ready). Exception: in CLASSIFY, pdb_ready is a function of `immediate`.
- Throughput:
  - 1-word instruction: 3 cycles (IDLE, CLASSIFY, OUT), with op_ready=1 and pdb_valid=1 continuously.
  - 2-word instruction: 3 cycles (extension accepted in CLASSIFY).
  - No back-to-back overlap is required.
- pab arithmetic: modulo 2^AW; 16'hFFFF+1 wraps to 16'h0000 silently.
- Flush has the highest priority, in any state:
  - Next state is IDLE, pab<=flush_addr, op_valid drops next cycle, has_ext<=0.
  - A pdb word presented in the flush cycle is not accepted: pdb_ready is forced to 0 while flush=1.
  - An op transfer coinciding with flush still completes; decode owns that instruction.
- Simultaneous flush and reset: reset wins.
- Reset mid-operation (any state): outputs return to reset values asynchronously; a partially assembled instruction is discarded.
- pdb_valid=0 in IDLE/EXT_WAIT: hold state, pab unchanged.
- X on pdb while pdb_valid=0 must not propagate to opcode/ext_word.

Decomposition:
- Shared package/header: state encodings (IDLE=2'd0, CLASSIFY=2'd1, EXT_WAIT=2'd2, OUT=2'd3), the `databus width macro, and the AW/RESET_PC defaults.
- Sub-module: pc_counter. AW-bit register with async reset to RESET_PC, load (flush_addr) and increment enable; load has priority over increment.
- The FSM and instruction holding registers stay in instr_ext_fetch.

Test Plan:
- Reset then single-word: reset, pdb=24'h200013 valid from cycle 1, immediate=0 in CLASSIFY -> op_valid in 3rd cycle, opcode=24'h200013, has_ext=0, ext_word=0, pab=RESET_PC+1.
- Two-word: pdb=24'h0AF080 then 24'h001234, immediate=1 in CLASSIFY -> opcode=24'h0AF080, ext_word=24'h001234, has_ext=1, pab=RESET_PC+2.
- Extension stall: immediate=1, pdb_valid low 4 cycles after opcode -> FSM in EXT_WAIT, pab frozen, op_valid=0; extension captured on first valid cycle; has_ext=1.
- Decode backpressure: op_ready=0 for 5 cycles in OUT -> op_valid=1, outputs stable, pdb_ready=0, pab unchanged; released on op_ready=1, returns to IDLE next cycle.
- Flush mid-instruction: flush=1, flush_addr=16'h0040 during EXT_WAIT -> next cycle IDLE, pab=16'h0040, op_valid=0, no word accepted in flush cycle.
- Wrap and async reset: pab=16'hFFFF accepting a word -> pab=16'h0000. Assert reset asynchronously mid-OUT -> op_valid=0 and pab=RESET_PC before the next clock edge.
